// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_4     = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Full set of datapath controls produced for one cycle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_ctrl_if;
  logic [5:0]  i_opcode;
  logic        i_zero;
  logic        i_mem_ready;
  logic        o_mem_req;
  logic        o_mem_write;
  logic        o_iord;
  logic        o_ir_write;
  logic        o_pc_write;
  logic        o_reg_write;
  logic        o_reg_dst;
  logic        o_mem_to_reg;
  logic        o_alu_src_a;
  logic [1:0]  o_alu_src_b;
  logic [1:0]  o_pc_src;
  logic [1:0]  o_alu_op;
  logic        o_illegal;
  logic [3:0]  o_state;
  logic [31:0] o_instr_count;

  modport master (
    input  i_opcode, i_zero, i_mem_ready,
    output o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_write,
           o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
           o_pc_src, o_alu_op, o_illegal, o_state, o_instr_count
  );

  modport slave (
    output i_opcode, i_zero, i_mem_ready,
    input  o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_write,
           o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
           o_pc_src, o_alu_op, o_illegal, o_state, o_instr_count
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control-word decode from the current FSM state.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   zero_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state control word; everything not named for a state stays 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_4;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = ALUSRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_B;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_write  = zero_i;
      end
      ST_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      ST_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: state register, sequencing and
// retired-instruction counter. Control outputs are combinational from state.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 -> PC on ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEM_ADR    | A + imm -> ALUOut (LW/SW address)
// MEM_READ   | load access, wait for ready
// MEM_WB     | MDR -> rt
// MEM_WRITE  | store access, wait for ready
// EXECUTE    | R-type ALU operation
// ALU_WB     | ALUOut -> rd
// BRANCH     | compare A/B, take ALUOut when zero
// JUMP       | jump target -> PC
// ADDI_EX    | A + imm
// ADDI_WB    | ALUOut -> rt
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst,
  multicycle_ctrl_if.master bus
);

  state_e      state_q, state_d;
  state_e      dec_state;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire;
  logic        illegal;
  ctrl_t       ctrl;

  // Under reset the decoder sees FETCH with no ready, so selects show
  // their FETCH values and the fetch enables stay low.
  assign dec_state = i_rst ? ST_FETCH : state_q;

  ctrl_decode u_decode (
    .state_i     (dec_state),
    .zero_i      (bus.i_zero),
    .mem_ready_i (bus.i_mem_ready & ~i_rst),
    .ctrl_o      (ctrl)
  );

  // Next-state, illegal-opcode detection and retire strobe.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:     if (bus.i_mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.i_opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADR;
          OP_R:         state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default: begin
            state_d = ST_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      ST_MEM_ADR:   state_d = (bus.i_opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (bus.i_mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: begin
        if (bus.i_mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXECUTE:   state_d = ST_ALU_WB;
      ST_ADDI_EX:   state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default:      state_d = ST_FETCH;
    endcase
    if (i_rst) begin
      state_d = ST_FETCH;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  // Counter wraps naturally at 32 bits.
  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) instr_count_d = instr_count_q + 32'd1;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_FETCH;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.o_mem_req     = ctrl.mem_req   & ~i_rst;
  assign bus.o_mem_write   = ctrl.mem_write & ~i_rst;
  assign bus.o_iord        = ctrl.iord;
  assign bus.o_ir_write    = ctrl.ir_write  & ~i_rst;
  assign bus.o_pc_write    = ctrl.pc_write  & ~i_rst;
  assign bus.o_reg_write   = ctrl.reg_write & ~i_rst;
  assign bus.o_reg_dst     = ctrl.reg_dst;
  assign bus.o_mem_to_reg  = ctrl.mem_to_reg;
  assign bus.o_alu_src_a   = ctrl.alu_src_a;
  assign bus.o_alu_src_b   = ctrl.alu_src_b;
  assign bus.o_pc_src      = ctrl.pc_src;
  assign bus.o_alu_op      = ctrl.alu_op;
  assign bus.o_illegal     = illegal;
  assign bus.o_state       = state_q;
  assign bus.o_instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams with random memory stalls.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] model_cnt;
  logic [14:0] obs_ctrl;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_ctrl = {bus.o_mem_req, bus.o_mem_write, bus.o_iord, bus.o_ir_write,
                     bus.o_pc_write, bus.o_reg_write, bus.o_reg_dst, bus.o_mem_to_reg,
                     bus.o_alu_src_a, bus.o_alu_src_b, bus.o_pc_src, bus.o_alu_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Expected controls per state, straight from the state table.
  function automatic logic [14:0] exp_ctrl(input int st, input bit rdy, input bit z);
    logic mreq, mw, iord, irw, pcw, rw, rdst, m2r, sa;
    logic [1:0] sb, ps, aop;
    {mreq, mw, iord, irw, pcw, rw, rdst, m2r, sa} = '0;
    sb = 2'b00; ps = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mreq = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mreq = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mreq = 1; mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pcw = z; end
      9:  begin ps = 2'b10; pcw = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {mreq, mw, iord, irw, pcw, rw, rdst, m2r, sa, sb, ps, aop};
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle: drive inputs at negedge, check combinational outputs shortly after.
  task automatic step(input int st, input bit rdy, input bit z);
    @(negedge clk);
    bus.i_mem_ready = rdy;
    bus.i_zero      = z;
    #1;
    chk("state", 32'(bus.o_state), 32'(st));
    chk("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(st, rdy, z)));
    chk("illegal", 32'(bus.o_illegal), 32'(st == 1 && !legal(bus.i_opcode)));
  endtask

  // Whole instruction from FETCH back to FETCH, then retirement check.
  task automatic run_instr(input logic [5:0] op, input bit z, input int fst, input int mst);
    bus.i_opcode = op;
    for (int i = 0; i < fst; i++) step(0, 1'b0, z);
    step(0, 1'b1, z);
    step(1, rbit(), z);
    case (op)
      6'b100011: begin
        step(2, rbit(), z);
        for (int i = 0; i < mst; i++) step(3, 1'b0, z);
        step(3, 1'b1, z);
        step(4, rbit(), z);
      end
      6'b101011: begin
        step(2, rbit(), z);
        for (int i = 0; i < mst; i++) step(5, 1'b0, z);
        step(5, 1'b1, z);
      end
      6'b000000: begin step(6, rbit(), z); step(7, rbit(), z); end
      6'b001000: begin step(10, rbit(), z); step(11, rbit(), z); end
      6'b000100: step(8, rbit(), z);
      6'b000010: step(9, rbit(), z);
      default: ;
    endcase
    if (legal(op)) model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
    chk("end_state", 32'(bus.o_state), 32'd0);
    chk("count", bus.o_instr_count, model_cnt);
  endtask

  logic [5:0] ops [6];

  initial begin
    checks = 0;
    errors = 0;
    model_cnt = 32'd0;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

    // Reset: outputs gated, selects at FETCH values.
    rst = 1'b1;
    bus.i_opcode = 6'b111111;
    bus.i_zero = 1'b1;
    bus.i_mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_count", bus.o_instr_count, 32'd0);
    chk("rst_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0) & 15'h3FFF));
    rst = 1'b0;
    bus.i_mem_ready = 1'b0;

    // LW, no stalls (states 0,1,2,3,4,0; count 0 -> 1).
    run_instr(6'b100011, 1'b0, 0, 0);
    // BEQ taken then not taken.
    run_instr(6'b000100, 1'b1, 0, 0);
    run_instr(6'b000100, 1'b0, 0, 0);
    // FETCH stalled for 3 cycles.
    run_instr(6'b000000, 1'b0, 3, 0);
    // Unsupported opcode.
    run_instr(6'b111111, 1'b0, 0, 0);
    // SW with two memory wait cycles.
    run_instr(6'b101011, 1'b0, 0, 2);

    // Reset during MEM_WRITE wait.
    bus.i_opcode = 6'b101011;
    step(0, 1'b1, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    step(5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.i_mem_ready = 1'b1;
    #1;
    chk("midrst_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0) & 15'h3FFF));
    @(posedge clk);
    #1;
    chk("midrst_state", 32'(bus.o_state), 32'd0);
    chk("midrst_count", bus.o_instr_count, 32'd0);
    model_cnt = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    bus.i_mem_ready = 1'b0;

    // Counter wrap: preload to all ones while FETCH is stalled, then a J.
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    model_cnt = 32'hFFFF_FFFF;
    #1;
    chk("preload", bus.o_instr_count, model_cnt);
    run_instr(6'b000010, 1'b0, 0, 0);
    chk("wrap", bus.o_instr_count, 32'd0);

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, rbit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives the select lines of the datapath multiplexers: ALU-A 2:1, ALU-B 4:1, PC-source 3:1, IorD 2:1, MemToReg 2:1 and RegDst 2:1. It also drives the register, IR, PC and memory enables, and it stalls on a single-port memory ready handshake.

## Interface
Parameters:
- none (widths fixed by the 32-bit datapath)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous and active-high
- i_opcode  in  6  IR[31:26], valid from DECODE onward
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory completes the current access this cycle
- o_mem_req  out  1  memory access request
- o_mem_write  out  1  request is a write (qualifies o_mem_req)
- o_iord  out  1  address select: 0 = PC, 1 = ALUOut
- o_ir_write  out  1  load IR
- o_pc_write  out  1  load PC (already combined with branch/zero)
- o_reg_write  out  1  register file write
- o_reg_dst  out  1  write register: 0 = rt, 1 = rd
- o_mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- o_alu_src_a  out  1  0 = PC, 1 = A
- o_alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- o_pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- o_alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- o_illegal  out  1  one-cycle pulse: unsupported opcode
- o_state  out  4  current state (debug)
- o_instr_count  out  32  retired-instruction counter

## Operation
- States: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- **FETCH**
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - When i_mem_ready=1: ir_write=1 and pc_write=1 → DECODE. Otherwise stay.
- **DECODE**
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: LW/SW → MEM_ADR; R → EXECUTE; BEQ → BRANCH; J → JUMP; ADDI → ADDI_EX.
  - Any other opcode: o_illegal=1 → FETCH; the instruction is not counted.
- **MEM_ADR**: alu_src_a=1, alu_src_b=10, alu_op=00. LW → MEM_READ, SW → MEM_WRITE.
- **MEM_READ**: mem_req=1, iord=1. i_mem_ready → MEM_WB, else stay.
- **MEM_WB**: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- **MEM_WRITE**: mem_req=1, mem_write=1, iord=1. i_mem_ready → FETCH, else stay.
- **EXECUTE**: alu_src_a=1, alu_src_b=00, alu_op=10 → ALU_WB.
- **ALU_WB**: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- **BRANCH**: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=i_zero → FETCH.
- **JUMP**: pc_src=10, pc_write=1 → FETCH.
- **ADDI_EX**: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDI_WB.
- **ADDI_WB**: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- Default values: any output not listed for a state is 0.
- o_instr_count:
  - Increments on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP or ADDI_WB.
  - Wraps 0xFFFFFFFF → 0.
- i_mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Timing
- All control outputs are combinational from state (plus i_mem_ready and i_zero where stated). State and counter are registered.
- While i_rst=1:
  - next state is FETCH and o_instr_count is 0 after the edge;
  - all enables, o_mem_req and o_illegal are forced to 0 in the same cycle;
  - selects take their FETCH values.
- Reset in mid-instruction abandons any pending access; no write enable is asserted on the reset cycle.
- Cycles per instruction with i_mem_ready held at 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
- Each low-ready cycle in a memory state adds exactly one cycle.
- Enables in wait states: o_ir_write and o_pc_write are never asserted in a FETCH wait cycle, and o_mem_req stays high throughout a wait.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum (4 bits);
  - opcode constants;
  - select-encoding constants (ALUSRCB_B/4/IMM/IMMSH, PCSRC_ALU/ALUOUT/JUMP, ALUOP_ADD/SUB/FUNCT).
- Sub-module ctrl_decode: combinational state + i_zero + i_mem_ready → control word. The top holds the state register, next-state logic and counter.

## Test plan
- LW with i_mem_ready=1: state sequence 0,1,2,3,4,0. MEM_WB asserts reg_write=1 with mem_to_reg=1 and reg_dst=0; o_instr_count goes 0→1.
- BEQ with i_zero=1, then with i_zero=0: the first asserts pc_write=1 with pc_src=01 in BRANCH, the second pc_write=0; each takes 3 cycles.
- FETCH with i_mem_ready low for 3 cycles: mem_req held at 1 with ir_write=0 and pc_write=0; ir_write and pc_write pulse exactly once on cycle 4.
- Opcode 111111: o_illegal pulses one cycle in DECODE, then FETCH; o_instr_count unchanged.
- i_rst asserted during MEM_WRITE wait: no write enables that cycle, o_state=0 and o_instr_count=0 afterwards.
- Preload o_instr_count to 0xFFFFFFFF, then run a J: counter wraps to 0.
